// File: rtl/hs_parallel_pkg.sv
// Shared definitions for the handshake parallel input port: FSM states,
// register map and the debug view exported by the top.
package hs_parallel_pkg;

    typedef enum logic [1:0] {
        S_READY     = 2'd0,
        S_WAIT_DAV  = 2'd1,
        S_WAIT_READ = 2'd2
    } state_t;

    localparam int   RSR_FI_BIT = 0;
    localparam logic ADDR_RSR   = 1'b0;
    localparam logic ADDR_RBR   = 1'b1;

    // Internal view for checkers: FSM state, input-full flag, bus drive enable.
    typedef struct packed {
        state_t state;
        logic   fi;
        logic   bus_oe;
    } hs_dbg_t;

    function automatic logic [7:0] rsr_value(input logic fi);
        logic [7:0] v;
        v             = 8'h00;
        v[RSR_FI_BIT] = fi;
        return v;
    endfunction

endpackage

// File: rtl/hs_parallel_in_if_if.sv
// CPU-bus and device-handshake signals of the parallel input port.
// Handshake: the device may drop dav_ (data valid) only while rfd=1; one byte
// transfers on the first clock edge that sees dav_=0 with rfd=1, after which
// rfd stays low until the device releases dav_ and the CPU has read RBR.
interface hs_parallel_in_if_if;
    logic       s_;
    logic       ior_;
    logic       a0;
    logic       dav_;
    logic       rfd;
    logic [7:0] byte_in;

    modport master (output s_, output ior_, output a0, output dav_, output byte_in, input rfd);
    modport slave  (input s_, input ior_, input a0, input dav_, input byte_in, output rfd);
endinterface

// File: rtl/hs_parallel_in_if.sv
// Handshake parallel input port: DAV_/RFD device side into RBR, CPU reads RSR/RBR.
// Optional interrupt output enabled by defining HS_PARALLEL_IN_IRQ_EN.
module hs_parallel_in_if
    import hs_parallel_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_,
    hs_parallel_in_if_if.slave    bus,
    output wire [7:0]             d7_d0,
`ifdef HS_PARALLEL_IN_IRQ_EN
    input  logic                  int_en,
    output logic                  irq,
`endif
    output hs_dbg_t               dbg
);

    state_t     state;
    logic [7:0] rbr;
    logic       fi;
    logic       rfd_q;

    logic       read_sel;
    logic       rbr_read;
    logic [7:0] rd_data;

    assign read_sel = ~bus.s_ & ~bus.ior_;
    assign rbr_read = read_sel & (bus.a0 == ADDR_RBR);
    assign rd_data  = (bus.a0 == ADDR_RBR) ? rbr : rsr_value(fi);
    assign d7_d0    = read_sel ? rd_data : 8'hzz;

    assign bus.rfd  = rfd_q;

    // FI clear by an RBR read is applied first so that a byte latched on the
    // same edge (only possible in S_READY) wins and sets FI again.
    always_ff @(posedge clock) begin
        if (reset_) begin
            rbr   <= 8'h00;
            fi    <= 1'b0;
            rfd_q <= 1'b1;
            state <= S_READY;
        end else begin
            if (rbr_read) begin
                fi <= 1'b0;
            end
            case (state)
                S_READY: begin
                    if (!bus.dav_) begin
                        rbr   <= bus.byte_in;
                        fi    <= 1'b1;
                        rfd_q <= 1'b0;
                        state <= S_WAIT_DAV;
                    end
                end
                S_WAIT_DAV: begin
                    if (bus.dav_) begin
                        state <= S_WAIT_READ;
                    end
                end
                S_WAIT_READ: begin
                    // Uses the registered FI, so rfd rises one edge after the read.
                    if (!fi) begin
                        rfd_q <= 1'b1;
                        state <= S_READY;
                    end
                end
                default: begin
                    rfd_q <= 1'b1;
                    state <= S_READY;
                end
            endcase
        end
    end

`ifdef HS_PARALLEL_IN_IRQ_EN
    assign irq = fi & int_en;
`endif

    assign dbg = '{state: state, fi: fi, bus_oe: read_sel};

endmodule

// File: tb/tb_hs_parallel_in_if.sv
// Bench for hs_parallel_in_if: cycle table for the main handshake and bus
// behaviour, plus scripted stall / mid-transfer reset / interrupt sequences.
module tb_hs_parallel_in_if;
    import hs_parallel_pkg::*;

    logic       clock;
    logic       reset_;
    wire  [7:0] d7_d0;
    hs_dbg_t    dbg;
`ifdef HS_PARALLEL_IN_IRQ_EN
    logic       int_en;
    logic       irq;
`endif

    hs_parallel_in_if_if bus ();

    hs_parallel_in_if dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus),
        .d7_d0  (d7_d0),
`ifdef HS_PARALLEL_IN_IRQ_EN
        .int_en (int_en),
        .irq    (irq),
`endif
        .dbg    (dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus.s_   = 1'b1;
        bus.ior_ = 1'b1;
        bus.a0   = 1'b0;
    endtask

    task automatic device_send(input logic [7:0] b);
        int n;
        n = 0;
        while (bus.rfd !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_rfd_ready", {7'b0, bus.rfd}, 8'h01);
        bus.dav_    = 1'b0;
        bus.byte_in = b;
        exp_q.push_back(b);
        tick();
        chk("send_rfd_low", {7'b0, bus.rfd}, 8'h00);
        chk("send_fi_set", {7'b0, dbg.fi}, 8'h01);
        bus.dav_ = 1'b1;
        tick();
    endtask

    task automatic cpu_read_rbr();
        logic [7:0] exp;
        bus.s_   = 1'b0;
        bus.ior_ = 1'b0;
        bus.a0   = ADDR_RBR;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rbr_read: got %02h with no byte expected", d7_d0);
        end else begin
            exp = exp_q.pop_front();
            chk("rbr_read_data", d7_d0, exp);
        end
        @(posedge clock);
        #1;
        bus_idle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       s_;
        logic       ior_;
        logic       a0;
        logic       dav_;
        logic [7:0] byte_in;
        logic       exp_oe;
        logic [7:0] exp_bus;
        logic       exp_rfd;
        logic       exp_fi;
        state_t     exp_state;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic ior, input logic a, input logic dav,
                                input logic [7:0] b, input logic oe, input logic [7:0] bv,
                                input logic rfd, input logic fi, input state_t st);
        vec_t v;
        v.s_ = s; v.ior_ = ior; v.a0 = a; v.dav_ = dav; v.byte_in = b;
        v.exp_oe = oe; v.exp_bus = bv; v.exp_rfd = rfd; v.exp_fi = fi; v.exp_state = st;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        // s ior a0 dav byte | oe bus | post-edge rfd fi state
        vecs[0]  = mk(0, 0, 0, 1, 8'h00, 1, 8'h00, 1, 0, S_READY);
        vecs[1]  = mk(1, 1, 0, 1, 8'h00, 0, 8'h00, 1, 0, S_READY);
        vecs[2]  = mk(0, 1, 0, 1, 8'h00, 0, 8'h00, 1, 0, S_READY);
        vecs[3]  = mk(1, 0, 1, 1, 8'h00, 0, 8'h00, 1, 0, S_READY);
        vecs[4]  = mk(1, 1, 0, 0, 8'h41, 0, 8'h00, 0, 1, S_WAIT_DAV);
        vecs[5]  = mk(0, 0, 0, 0, 8'h42, 1, 8'h01, 0, 1, S_WAIT_DAV);
        vecs[6]  = mk(1, 1, 0, 0, 8'h42, 0, 8'h00, 0, 1, S_WAIT_DAV);
        vecs[7]  = mk(1, 1, 0, 0, 8'h42, 0, 8'h00, 0, 1, S_WAIT_DAV);
        vecs[8]  = mk(1, 1, 0, 0, 8'h42, 0, 8'h00, 0, 1, S_WAIT_DAV);
        vecs[9]  = mk(1, 1, 0, 0, 8'h42, 0, 8'h00, 0, 1, S_WAIT_DAV);
        vecs[10] = mk(1, 1, 0, 1, 8'h42, 0, 8'h00, 0, 1, S_WAIT_READ);
        vecs[11] = mk(0, 1, 1, 1, 8'h00, 0, 8'h00, 0, 1, S_WAIT_READ);
        vecs[12] = mk(1, 0, 1, 1, 8'h00, 0, 8'h00, 0, 1, S_WAIT_READ);
        vecs[13] = mk(0, 0, 0, 1, 8'h00, 1, 8'h01, 0, 1, S_WAIT_READ);
        vecs[14] = mk(0, 0, 1, 1, 8'h00, 1, 8'h41, 0, 0, S_WAIT_READ);
        vecs[15] = mk(1, 1, 0, 1, 8'h00, 0, 8'h00, 1, 0, S_READY);
        vecs[16] = mk(0, 0, 1, 1, 8'h00, 1, 8'h41, 1, 0, S_READY);
        vecs[17] = mk(1, 1, 0, 0, 8'h55, 0, 8'h00, 0, 1, S_WAIT_DAV);
        vecs[18] = mk(0, 0, 1, 1, 8'h55, 1, 8'h55, 0, 0, S_WAIT_READ);
        vecs[19] = mk(1, 1, 0, 1, 8'h00, 0, 8'h00, 1, 0, S_READY);

        // ---- reset ----
        reset_      = 1'b1;
        bus_idle();
        bus.dav_    = 1'b1;
        bus.byte_in = 8'h00;
`ifdef HS_PARALLEL_IN_IRQ_EN
        int_en      = 1'b1;
`endif
        tick();
        tick();
        chk("reset_rfd", {7'b0, bus.rfd}, 8'h01);
        chk("reset_fi", {7'b0, dbg.fi}, 8'h00);
        chk("reset_state", {6'b0, dbg.state}, {6'b0, S_READY});
        chk("reset_bus_off", {7'b0, dbg.bus_oe}, 8'h00);
`ifdef HS_PARALLEL_IN_IRQ_EN
        chk("reset_irq", {7'b0, irq}, 8'h00);
`endif
        reset_ = 1'b0;

        // ---- table ----
        foreach (vecs[i]) begin
            bus.s_      = vecs[i].s_;
            bus.ior_    = vecs[i].ior_;
            bus.a0      = vecs[i].a0;
            bus.dav_    = vecs[i].dav_;
            bus.byte_in = vecs[i].byte_in;
            #1;
            chk($sformatf("v%0d_bus_oe", i), {7'b0, dbg.bus_oe}, {7'b0, vecs[i].exp_oe});
            if (vecs[i].exp_oe)
                chk($sformatf("v%0d_bus_data", i), d7_d0, vecs[i].exp_bus);
            tick();
            chk($sformatf("v%0d_rfd", i), {7'b0, bus.rfd}, {7'b0, vecs[i].exp_rfd});
            chk($sformatf("v%0d_fi", i), {7'b0, dbg.fi}, {7'b0, vecs[i].exp_fi});
            chk($sformatf("v%0d_state", i), {6'b0, dbg.state}, {6'b0, vecs[i].exp_state});
        end
        bus_idle();
        bus.dav_ = 1'b1;

        // ---- no-read stall: device byte ignored until RBR is read ----
        device_send(8'h30);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_rfd", {7'b0, bus.rfd}, 8'h00);
        end
        bus.dav_    = 1'b0;
        bus.byte_in = 8'h31;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ignore_state", {6'b0, dbg.state}, {6'b0, S_WAIT_READ});
        end
        cpu_read_rbr();
        chk("stall_fi_clear", {7'b0, dbg.fi}, 8'h00);
        tick();
        chk("stall_rfd_up", {7'b0, bus.rfd}, 8'h01);
        chk("stall_ready", {6'b0, dbg.state}, {6'b0, S_READY});
        exp_q.push_back(8'h31);
        tick();
        chk("stall_accept", {6'b0, dbg.state}, {6'b0, S_WAIT_DAV});
        bus.dav_ = 1'b1;
        tick();
        cpu_read_rbr();
        tick();

        // ---- reset in the middle of a transfer ----
        bus.dav_    = 1'b0;
        bus.byte_in = 8'h77;
        tick();
        chk("midrst_pre_state", {6'b0, dbg.state}, {6'b0, S_WAIT_DAV});
        reset_ = 1'b1;
        tick();
        reset_   = 1'b0;
        bus.dav_ = 1'b1;
        chk("midrst_fi", {7'b0, dbg.fi}, 8'h00);
        chk("midrst_rfd", {7'b0, bus.rfd}, 8'h01);
        chk("midrst_state", {6'b0, dbg.state}, {6'b0, S_READY});
        bus.s_   = 1'b0;
        bus.ior_ = 1'b0;
        bus.a0   = ADDR_RBR;
        #1;
        chk("midrst_rbr", d7_d0, 8'h00);
        tick();
        bus_idle();
        tick();

`ifdef HS_PARALLEL_IN_IRQ_EN
        // ---- interrupt ----
        int_en = 1'b0;
        device_send(8'h66);
        chk("irq_masked", {7'b0, irq}, 8'h00);
        int_en = 1'b1;
        #1;
        chk("irq_set", {7'b0, irq}, 8'h01);
        cpu_read_rbr();
        chk("irq_clear", {7'b0, irq}, 8'h00);
        tick();
`endif

        chk("scoreboard_empty", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
